translate_stream: RTL

- Parametrised successor to the single-beat point translator.
- Accepts a stream of packed 2-D signed coordinate pairs and adds a runtime-programmable (dx, dy) offset to every point in the beat.
- 2-stage pipeline with full valid/ready handshake on both sides, so it can sit between the point source and the rasteriser under backpressure.
- Reports per-beat overflow and keeps a running count of output beats.

---
 rtl/translate_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/translate_stream.sv
// Two-stage valid/ready pipeline adding a programmable (dx, dy) to every point.
// Define TRANSLATE_SATURATE_EN to clamp overflowing coordinates instead of wrapping.
module translate_stream #(
  parameter int COORD_WIDTH = 16,
  parameter int NUM_POINTS  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [COORD_WIDTH-1:0]              offset_x_in,
  input  logic [COORD_WIDTH-1:0]              offset_y_in,
  input  logic                                offset_valid_in,
  input  logic [2*COORD_WIDTH*NUM_POINTS-1:0] data_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  output logic [2*COORD_WIDTH*NUM_POINTS-1:0] data_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                overflow_out,
  output logic [COUNT_WIDTH-1:0]              beat_count_out
);

  localparam int W  = COORD_WIDTH;
  localparam int L  = 2 * NUM_POINTS;
  localparam int DW = W * L;

  logic [W-1:0]  ox_q, oy_q;
  logic [DW-1:0] sum_d;
  logic [L-1:0]  lane_ovf;

  logic          s1_valid_q, s2_valid_q;
  logic [DW-1:0] s1_data_q, s2_data_q;
  logic [L-1:0]  s1_ovf_q;
  logic          s2_ovf_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  logic in_xfer, out_xfer, s1_load, s2_load;

  // Odd lanes are x (upper half of a point), even lanes are y.
  for (genvar g = 0; g < L; g++) begin : g_lane
    logic [W-1:0] c, o;
    logic [W:0]   s;
    assign c = data_in[g*W +: W];
    if (g % 2 == 1) begin : g_x
      assign o = ox_q;
    end else begin : g_y
      assign o = oy_q;
    end
    assign s = {c[W-1], c} + {o[W-1], o};
    assign lane_ovf[g] = s[W] ^ s[W-1];
`ifdef TRANSLATE_SATURATE_EN
    assign sum_d[g*W +: W] = !lane_ovf[g] ? s[W-1:0] :
                             s[W] ? {1'b1, {(W-1){1'b0}}} :
                                    {1'b0, {(W-1){1'b1}}};
`else
    assign sum_d[g*W +: W] = s[W-1:0];
`endif
  end

  assign s2_load   = !s2_valid_q || ready_in;
  assign s1_load   = !s1_valid_q || s2_load;
  assign ready_out = !rst_in && s1_load;
  assign in_xfer   = valid_in && ready_out;
  assign out_xfer  = s2_valid_q && ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ox_q       <= '0;
      oy_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ovf_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (offset_valid_in) begin
        ox_q <= offset_x_in;
        oy_q <= offset_y_in;
      end
      if (s1_load) begin
        s1_valid_q <= in_xfer;
        if (in_xfer) begin
          s1_data_q <= sum_d;
          s1_ovf_q  <= lane_ovf;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
          s2_ovf_q  <= |s1_ovf_q;
        end
      end
      if (out_xfer) cnt_q <= cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign data_out       = s2_data_q;
  assign valid_out      = s2_valid_q;
  assign overflow_out   = s2_ovf_q;
  assign beat_count_out = cnt_q;

endmodule
